imm_packer: RTL and testbench

Instruction-word assembler: the encode direction of `immediateExtender`. It takes decoded fields and a 32-bit immediate and produces the packed RV32I instruction word, with optional representability checking of the immediate. It sits in the test/stimulus path and the self-modifying/trap-return paths that must rebuild instruction words. It is a two-stage valid/ready pipeline with full throughput and backpressure.

---
 rtl/imm_pkg.sv | 48 ++++
 rtl/imm_field_pack.sv | 88 ++++++++
 rtl/imm_packer.sv | 75 +++++++
 tb/tb_imm_packer.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// Shared RV32I instruction-format constants for imm_packer and immediateExtender.
// Format encodings, field bit positions, opcodes and the request bundle type.
package imm_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  localparam int OPC_LSB = 0;
  localparam int RD_LSB  = 7;
  localparam int F3_LSB  = 12;
  localparam int RS1_LSB = 15;
  localparam int RS2_LSB = 20;
  localparam int F7_LSB  = 25;

  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JAL    = 7'h6F;

  // fmt kept as raw bits: 6/7 must survive to the packer to be flagged
  typedef struct packed {
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
  } imm_req_t;

  // True when v is the sign-extension of v[msb:0].
  function automatic logic sext_fits(input logic [31:0] v, input int msb);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 32; i++)
      if (i > msb && v[i] != v[msb]) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/imm_field_pack.sv
// Combinational RV32I field packer. Range checks present only with
// IMM_RANGE_CHECK_EN defined; otherwise err flags illegal formats only.
module imm_field_pack
  import imm_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        err
);

  logic legal;

  always_comb begin
    word = '0;
    word[OPC_LSB +: 7] = opcode;
    legal = 1'b1;
    case (fmt)
      FMT_R: begin
        word[RD_LSB  +: 5] = rd;
        word[F3_LSB  +: 3] = funct3;
        word[RS1_LSB +: 5] = rs1;
        word[RS2_LSB +: 5] = rs2;
        word[F7_LSB  +: 7] = funct7;
      end
      FMT_I: begin
        word[RD_LSB  +: 5] = rd;
        word[F3_LSB  +: 3] = funct3;
        word[RS1_LSB +: 5] = rs1;
        word[31:20]        = imm[11:0];
      end
      FMT_S: begin
        word[11:7]         = imm[4:0];
        word[F3_LSB  +: 3] = funct3;
        word[RS1_LSB +: 5] = rs1;
        word[RS2_LSB +: 5] = rs2;
        word[31:25]        = imm[11:5];
      end
      FMT_B: begin
        word[7]            = imm[11];
        word[11:8]         = imm[4:1];
        word[F3_LSB  +: 3] = funct3;
        word[RS1_LSB +: 5] = rs1;
        word[RS2_LSB +: 5] = rs2;
        word[30:25]        = imm[10:5];
        word[31]           = imm[12];
      end
      FMT_U: begin
        word[RD_LSB +: 5] = rd;
        word[31:12]       = imm[31:12];
      end
      FMT_J: begin
        word[RD_LSB +: 5] = rd;
        word[19:12]       = imm[19:12];
        word[20]          = imm[11];
        word[30:21]       = imm[10:1];
        word[31]          = imm[20];
      end
      default: legal = 1'b0;
    endcase
  end

`ifdef IMM_RANGE_CHECK_EN
  logic rng_ok;

  always_comb begin
    rng_ok = 1'b1;
    case (fmt)
      FMT_I, FMT_S: rng_ok = sext_fits(imm, 11);
      FMT_B:        rng_ok = sext_fits(imm, 12) && !imm[0];
      FMT_J:        rng_ok = sext_fits(imm, 20) && !imm[0];
      FMT_U:        rng_ok = (imm[11:0] == 12'd0);
      default:      rng_ok = 1'b1;
    endcase
  end

  assign err = !legal || !rng_ok;
`else
  assign err = !legal;
`endif

endmodule

// File: rtl/imm_packer.sv
// Two-stage valid/ready RV32I instruction assembler (S1 bundle reg, S2 output reg).
// Optional immediate range checking via IMM_RANGE_CHECK_EN.
module imm_packer
  import imm_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_fmt,
  input  logic [6:0]  in_opcode,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_imm_err
);

  localparam int STAGES = 2;

  imm_req_t          s1_q;
  logic [STAGES:1]   vld_pipe;
  logic              s1_adv, s2_adv;
  logic [31:0]       pk_word;
  logic              pk_err;

  assign s2_adv    = !vld_pipe[2] || out_ready;
  assign s1_adv    = vld_pipe[1] && s2_adv;
  assign in_ready  = !vld_pipe[1] || s2_adv;
  assign out_valid = vld_pipe[2];

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe    <= '0;
      s1_q        <= '0;
      out_instr   <= '0;
      out_imm_err <= 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        vld_pipe[1] <= 1'b1;
        s1_q        <= '{fmt: in_fmt, opcode: in_opcode, rd: in_rd, rs1: in_rs1,
                         rs2: in_rs2, funct3: in_funct3, funct7: in_funct7, imm: in_imm};
      end else if (s1_adv) begin
        vld_pipe[1] <= 1'b0;
      end
      // S2 keeps its last word when it drains empty
      if (s2_adv) begin
        vld_pipe[2] <= vld_pipe[1];
        if (s1_adv) begin
          out_instr   <= pk_word;
          out_imm_err <= pk_err;
        end
      end
    end
  end

  imm_field_pack u_pack (
    .fmt    (s1_q.fmt),
    .opcode (s1_q.opcode),
    .rd     (s1_q.rd),
    .rs1    (s1_q.rs1),
    .rs2    (s1_q.rs2),
    .funct3 (s1_q.funct3),
    .funct7 (s1_q.funct7),
    .imm    (s1_q.imm),
    .word   (pk_word),
    .err    (pk_err)
  );

endmodule

// File: tb/tb_imm_packer.sv
// Directed bench for imm_packer: packing per format, range errors, latency,
// throughput, backpressure and mid-flight reset.
module tb_imm_packer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, in_ready;
  logic [2:0]  in_fmt = '0;
  logic [6:0]  in_opcode = '0, in_funct7 = '0;
  logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [2:0]  in_funct3 = '0;
  logic [31:0] in_imm = '0;
  logic        out_valid, out_ready = 1'b1, out_imm_err;
  logic [31:0] out_instr;

  localparam logic RC =
`ifdef IMM_RANGE_CHECK_EN
    1'b1;
`else
    1'b0;
`endif

  imm_packer dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_imm_err(out_imm_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] fmt; logic [6:0] op; logic [4:0] rd, rs1, rs2;
    logic [2:0] f3; logic [6:0] f7; logic [31:0] imm;
  } bnd_t;

  int n_tests = 0, n_fail = 0;
  bnd_t vq[$];
  int vidx, cyc;
  logic [31:0] got_q[$];
  int got_cyc[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic bnd_t mk(int fmt, int op, int rd, int rs1, int rs2, int f3, int f7, logic [31:0] imm);
    bnd_t b;
    b.fmt = 3'(fmt); b.op = 7'(op); b.rd = 5'(rd); b.rs1 = 5'(rs1);
    b.rs2 = 5'(rs2); b.f3 = 3'(f3); b.f7 = 7'(f7); b.imm = imm;
    return b;
  endfunction

  task automatic drive(input bnd_t b, input logic v);
    in_valid = v; in_fmt = b.fmt; in_opcode = b.op; in_rd = b.rd; in_rs1 = b.rs1;
    in_rs2 = b.rs2; in_funct3 = b.f3; in_funct7 = b.f7; in_imm = b.imm;
  endtask

  // One loop iteration per clock: offer vq[vidx], record accepts and output transfers.
  task automatic run(input int n);
    logic acc;
    for (int c = 0; c < n; c++) begin
      if (vidx < vq.size()) drive(vq[vidx], 1'b1);
      else drive(mk(0, 0, 0, 0, 0, 0, 0, 32'h0), 1'b0);
      @(negedge clk);
      acc = in_valid && in_ready;
      if (out_valid && out_ready) begin
        got_q.push_back(out_instr);
        got_cyc.push_back(cyc);
      end
      @(posedge clk); #1;
      cyc++;
      if (acc) vidx++;
    end
  endtask

  // Single bundle, no backpressure: word visible after the second edge.
  task automatic send_one(input string tag, input bnd_t b, input logic [31:0] exp_w, input logic exp_e);
    out_ready = 1'b1;
    drive(b, 1'b1);
    @(negedge clk);
    chk({tag, "/in_ready"}, 32'(in_ready), 1);
    @(posedge clk); #1;
    drive(b, 1'b0);
    chk({tag, "/vld_early"}, 32'(out_valid), 0);
    @(posedge clk); #1;
    chk({tag, "/vld"}, 32'(out_valid), 1);
    chk({tag, "/instr"}, out_instr, exp_w);
    chk({tag, "/err"}, 32'(out_imm_err), 32'(exp_e));
    @(posedge clk); #1;
    chk({tag, "/drain"}, 32'(out_valid), 0);
  endtask

  bnd_t v_b, v_r, v_u, v_i, v_s;
  logic [31:0] held;

  initial begin
    v_b = mk(3, 'h63, 0, 6, 13, 6, 0, 32'd6);
    v_r = mk(0, 'h33, 1, 2, 3, 0, 'h20, 32'hDEAD_BEEF);
    v_u = mk(4, 'h37, 13, 0, 0, 0, 0, 32'h8000_7000);
    v_i = mk(1, 'h13, 4, 0, 0, 6, 0, 32'd1);
    v_s = mk(2, 'h23, 0, 10, 8, 3, 0, 32'h2C);

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst/vld", 32'(out_valid), 0);
    chk("rst/instr", out_instr, 0);
    chk("rst/err", 32'(out_imm_err), 0);
    chk("rst/in_ready", 32'(in_ready), 1);

    send_one("B", v_b, 32'h00D3_6363, 1'b0);
    send_one("R", v_r, 32'h4031_00B3, 1'b0);
    send_one("J-4", mk(5, 'h6F, 0, 31, 31, 7, 'h7F, 32'hFFFF_FFFC), 32'hFFDF_F06F, 1'b0);
    send_one("J3", mk(5, 'h6F, 1, 0, 0, 0, 0, 32'd3), 32'h0020_00EF, RC);
    send_one("I800", mk(1, 'h13, 1, 2, 0, 0, 0, 32'h800), 32'h8001_0093, RC);
    send_one("U1", mk(4, 'h37, 1, 0, 0, 0, 0, 32'd1), 32'h0000_00B7, RC);
    send_one("fmt7", mk(7, 'h33, 5, 6, 7, 3, 'h7F, 32'hFFFF_FFFF), 32'h0000_0033, 1'b1);

    // back-to-back U, I, S
    vq = '{v_u, v_i, v_s}; vidx = 0; cyc = 0;
    got_q.delete(); got_cyc.delete();
    run(6);
    chk("b2b/accepted", vidx, 3);
    chk("b2b/count", got_q.size(), 3);
    if (got_q.size() == 3) begin
      chk("b2b/U", got_q[0], 32'h8000_76B7);
      chk("b2b/I", got_q[1], 32'h0010_6213);
      chk("b2b/S", got_q[2], 32'h0285_3623);
      chk("b2b/gap01", got_cyc[1] - got_cyc[0], 1);
      chk("b2b/gap12", got_cyc[2] - got_cyc[1], 1);
    end

    // backpressure: 3 offered over 5 stalled cycles
    vq = '{v_r, v_b, v_s}; vidx = 0;
    got_q.delete(); got_cyc.delete();
    out_ready = 1'b0;
    run(2);
    held = out_instr;
    run(3);
    chk("bp/accepted", vidx, 2);
    chk("bp/in_ready", 32'(in_ready), 0);
    chk("bp/vld", 32'(out_valid), 1);
    chk("bp/stable", out_instr, held);
    chk("bp/head", out_instr, 32'h4031_00B3);
    out_ready = 1'b1;
    run(1);
    chk("bp/full_accept", vidx, 3);
    run(6);
    chk("bp/count", got_q.size(), 3);
    if (got_q.size() == 3) begin
      chk("bp/w0", got_q[0], 32'h4031_00B3);
      chk("bp/w1", got_q[1], 32'h00D3_6363);
      chk("bp/w2", got_q[2], 32'h0285_3623);
    end
    chk("bp/empty", 32'(out_valid), 0);

    // reset with both stages full
    vq = '{v_u, v_i}; vidx = 0;
    out_ready = 1'b0;
    run(3);
    chk("rf/accepted", vidx, 2);
    chk("rf/vld", 32'(out_valid), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rf/vld0", 32'(out_valid), 0);
    chk("rf/instr0", out_instr, 0);
    chk("rf/in_ready", 32'(in_ready), 1);
    vq.delete(); vidx = 0;
    got_q.delete(); got_cyc.delete();
    out_ready = 1'b1;
    run(5);
    chk("rf/no_stale", got_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
